shift_register_piso_tx: RTL and testbench

Parallel-in, serial-out transmitter: the transmit end of the 1-bit serial link whose receive end is the 4-bit left (MSB-first) shift register. It accepts a WIDTH-bit word over a valid/ready handshake, then drives it out one bit per consumed cycle, MSB first. A downstream `out <= {out[WIDTH-2:0], d}` receiver holds the original word after the last bit. Back-to-back words stream with no idle gap.

---
 rtl/shift_pkg.sv | 5 +
 rtl/shift_register_piso_tx.sv | 70 +++++++
 tb/tb_shift_register_piso_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the 1-bit serial link shift registers.
package shift_pkg;
    typedef enum logic {IDLE, SHIFT} piso_state_t;
    localparam int SHIFT_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/shift_register_piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready word load.
// Back-to-back words reload on the last consumed bit with no idle gap.
module shift_register_piso_tx
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             at_last;
    logic             xfer;

    assign at_last    = (state == SHIFT) && (bit_cnt == LAST);
    assign load_ready = !rst && ((state == IDLE) || (at_last && shift_en));
    assign xfer       = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state   <= SHIFT;
                        shreg   <= load_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (!at_last) begin
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (xfer) begin
                            shreg   <= load_data;
                            bit_cnt <= '0;
                        end else begin
                            state   <= IDLE;
                            shreg   <= '0;
                            bit_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sout       = shreg[WIDTH-1];
    assign sout_valid = (state == SHIFT);
    assign sout_last  = at_last;
    assign busy       = sout_valid;
endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Bench for shift_register_piso_tx: vector table, hand sequences,
// and a bit scoreboard fed on every accepted word.
module tb_shift_register_piso_tx;
    logic       clk = 0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       shift_en;
    logic       sout;
    logic       sout_valid;
    logic       sout_last;
    logic       busy;
    logic [3:0] rx;

    int npass = 0;
    int ntot  = 0;

    logic [1:0] sb[$];

    shift_register_piso_tx #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .shift_en(shift_en),
        .sout(sout),
        .sout_valid(sout_valid),
        .sout_last(sout_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // loopback MSB-first receiver
    always @(posedge clk) begin
        if (rst) rx <= '0;
        else     rx <= {rx[2:0], sout};
    end

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, got, exp,
                      $time);
    endtask

    // scoreboard: compare the presented bit, pop when consumed
    always @(negedge clk) begin
        logic [1:0] e;
        if (sout_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {2'b0, sout, sout_last}, 4'b1111);
            end else begin
                e = sb[0];
                chk("sb_bit", {2'b0, sout, sout_last}, {2'b0, e});
                if (shift_en && !rst) void'(sb.pop_front());
            end
        end
        if (rst) sb.delete();
        else if (load_valid && load_ready) begin
            sb.push_back({load_data[3], 1'b0});
            sb.push_back({load_data[2], 1'b0});
            sb.push_back({load_data[1], 1'b0});
            sb.push_back({load_data[0], 1'b1});
        end
    end

    task automatic step(input logic r, input logic lv,
                        input logic [3:0] d, input logic se);
        @(posedge clk);
        #1;
        rst        = r;
        load_valid = lv;
        load_data  = d;
        shift_en   = se;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic       lv;
        logic [3:0] d;
        logic       se;
        logic       rdy;
        logic       so;
        logic       vl;
        logic       ls;
        logic       rxc;
        logic [3:0] rx;
    } vec_t;

    vec_t tbl [15];
    int   nlast;

    initial begin
        // single word 1011, then back-to-back 1011 + 0110
        tbl[0]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011};
        tbl[6]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[7]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[8]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[9]  = '{1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110};

        rst = 1; load_valid = 0; load_data = 0; shift_en = 0;
        step(1, 1, 4'b1111, 1);
        step(1, 1, 4'b1111, 1);
        chk("rst_ready", {3'b0, load_ready}, 4'b0000);
        chk("rst_outs", {sout, sout_valid, sout_last, busy}, 4'b0000);

        for (int i = 0; i < 15; i++) begin
            step(0, tbl[i].lv, tbl[i].d, tbl[i].se);
            chk($sformatf("vec%0d_ready", i), {3'b0, load_ready},
                {3'b0, tbl[i].rdy});
            chk($sformatf("vec%0d_outs", i), {sout, sout_valid, sout_last, busy},
                {tbl[i].so, tbl[i].vl, tbl[i].ls, tbl[i].vl});
            if (tbl[i].rxc) chk($sformatf("vec%0d_rx", i), rx, tbl[i].rx);
        end

        // stall: 1100 with two stalled cycles on the first bit
        step(0, 1, 4'b1100, 1);
        nlast = 0;
        step(0, 0, 4'b0000, 0);
        chk("stall_b0a", {2'b0, sout, sout_valid}, 4'b0011);
        nlast += int'(sout_last);
        step(0, 0, 4'b0000, 0);
        chk("stall_b0b", {2'b0, sout, sout_valid}, 4'b0011);
        nlast += int'(sout_last);
        step(0, 0, 4'b0000, 1);
        chk("stall_b0c", {2'b0, sout, sout_valid}, 4'b0011);
        nlast += int'(sout_last);
        step(0, 0, 4'b0000, 1);
        chk("stall_b1", {2'b0, sout, sout_valid}, 4'b0011);
        nlast += int'(sout_last);
        step(0, 0, 4'b0000, 1);
        chk("stall_b2", {2'b0, sout, sout_valid}, 4'b0001);
        nlast += int'(sout_last);
        step(0, 0, 4'b0000, 1);
        chk("stall_b3", {2'b0, sout, sout_last}, 4'b0001);
        nlast += int'(sout_last);
        chk("stall_nlast", 4'(nlast), 4'd1);

        // busy offer at bit_cnt==1 is refused
        step(0, 1, 4'b1011, 1);
        step(0, 0, 4'b0000, 1);
        step(0, 1, 4'b0001, 1);
        chk("busy_ready", {3'b0, load_ready}, 4'b0000);
        chk("busy_b1", {2'b0, sout, sout_valid}, 4'b0001);
        step(0, 0, 4'b0000, 1);
        chk("busy_b2", {2'b0, sout, sout_valid}, 4'b0011);
        step(0, 0, 4'b0000, 1);
        chk("busy_b3", {1'b0, sout, sout_valid, sout_last}, 4'b0111);
        step(0, 0, 4'b0000, 1);
        chk("busy_idle", {sout, sout_valid, sout_last, busy}, 4'b0000);

        // reset mid-word, then a clean 0011
        step(0, 1, 4'b1011, 1);
        step(0, 0, 4'b0000, 1);
        step(0, 0, 4'b0000, 1);
        step(1, 1, 4'b1111, 1);
        chk("mid_rst_ready", {3'b0, load_ready}, 4'b0000);
        step(0, 0, 4'b0000, 1);
        chk("mid_rst_outs", {sout, sout_valid, sout_last, busy}, 4'b0000);
        chk("mid_rst_ready2", {3'b0, load_ready}, 4'b0001);
        load_valid = 1;
        load_data  = 4'b0011;
        step(0, 0, 4'b0000, 1);
        chk("rl_b0", {1'b0, sout, sout_valid, sout_last}, 4'b0010);
        step(0, 0, 4'b0000, 1);
        chk("rl_b1", {1'b0, sout, sout_valid, sout_last}, 4'b0010);
        step(0, 0, 4'b0000, 1);
        chk("rl_b2", {1'b0, sout, sout_valid, sout_last}, 4'b0110);
        step(0, 0, 4'b0000, 1);
        chk("rl_b3", {1'b0, sout, sout_valid, sout_last}, 4'b0111);
        step(0, 0, 4'b0000, 1);
        chk("rl_rx", rx, 4'b0011);

        // idle hygiene with shift_en toggling
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'b1010, 1'(i & 1));
            chk($sformatf("idle%0d", i), {sout, sout_valid, sout_last, busy},
                4'b0000);
            chk($sformatf("idle%0d_ready", i), {3'b0, load_ready}, 4'b0001);
        end

        chk("sb_drained", 4'(sb.size()), 4'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
